// File: rtl/seg7_pkg.sv
// Shared 7-segment code constants and capture FSM states.
// Used by both the forward display driver and the capture decoder.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h5f;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h3b;
   localparam logic [6:0] SEG_3     = 7'h2f;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6d;
   localparam logic [6:0] SEG_6     = 7'h7d;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7f;
   localparam logic [6:0] SEG_9     = 7'h6f;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7c;
   localparam logic [6:0] SEG_C     = 7'h59;
   localparam logic [6:0] SEG_D     = 7'h3e;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_pattern_match.sv
// Combinational reverse lookup: 7-bit segment code to hex nibble.
// hit is low for any code outside the 16-entry table.
module seg7_pattern_match
   import seg7_pkg::*;
(
   input  logic [6:0] code,
   output logic       hit,
   output logic [3:0] nibble
);

   // table lookup; unlisted codes miss
   always_comb begin
      hit    = 1'b1;
      nibble = 4'h0;
      case (code)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'ha;
         SEG_B:   nibble = 4'hb;
         SEG_C:   nibble = 4'hc;
         SEG_D:   nibble = 4'hd;
         SEG_E:   nibble = 4'he;
         SEG_F:   nibble = 4'hf;
         default: hit    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Multiplexed 7-segment bus receiver: settle, capture, decode per digit.
// Optional SEG7_CAP_BLANK_EN treats code 00 as a recognised blank digit.
module seg7_capture_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [7:0]              i_seg,
   input  logic [NUM_DIGITS-1:0]   i_digit_sel,
   output logic [4*NUM_DIGITS-1:0] o_digits,
   output logic [NUM_DIGITS-1:0]   o_dp,
   output logic [NUM_DIGITS-1:0]   o_valid,
   output logic [NUM_DIGITS-1:0]   o_err,
   output logic                    o_sel_err,
   output logic                    o_frame
);

   localparam logic [15:0] CNT_MAX    = 16'hffff;
   localparam logic [15:0] STABLE_CNT = 16'(STABLE_CYCLES);

   logic [NUM_DIGITS-1:0] s_sel, p_sel, mask, cap_mask, mask_or;
   logic [7:0]            s_seg, p_seg;
   logic                  multi_q;
   state_t                state, state_nx;
   logic [15:0]           cnt, cnt_nx;
   logic                  cap, onehot, multi, same;
   logic                  hit, blank;
   logic [3:0]            nibble;

   assign onehot = (s_sel != '0) &&
                   ((s_sel & (s_sel - NUM_DIGITS'(1))) == '0);
   assign multi  = (s_sel != '0) && !onehot;
   assign same   = (s_sel == p_sel) && (s_seg == p_seg);

`ifdef SEG7_CAP_BLANK_EN
   assign blank = (s_seg[6:0] == SEG_BLANK);
`else
   assign blank = 1'b0;
`endif

   seg7_pattern_match u_match (
      .code   (s_seg[6:0]),
      .hit    (hit),
      .nibble (nibble)
   );

   // input sampling plus one-cycle history for the stability compare
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s_sel <= '0;
         s_seg <= '0;
         p_sel <= '0;
         p_seg <= '0;
      end else begin
         s_sel <= i_digit_sel;
         s_seg <= i_seg;
         p_sel <= s_sel;
         p_seg <= s_seg;
      end
   end

   // state and dwell counter registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // settle/hold sequencing; capture fires on the last stable sample
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cap      = 1'b0;
      unique case (state)
         IDLE: begin
            if (onehot) begin
               state_nx = SETTLE;
               cnt_nx   = 16'd1;
            end
         end
         SETTLE: begin
            if (!onehot) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (!same) begin
               cnt_nx = 16'd1;
            end else begin
               cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
               if (cnt_nx >= STABLE_CNT) begin
                  cap      = 1'b1;
                  state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            if (!onehot) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (!same) begin
               state_nx = SETTLE;
               cnt_nx   = 16'd1;
            end else begin
               cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // per-digit capture registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_digits <= '0;
         o_dp     <= '0;
         o_valid  <= '0;
         o_err    <= '0;
      end else if (cap) begin
         for (int n = 0; n < NUM_DIGITS; n++) begin
            if (s_sel[n]) begin
               if (blank) begin
                  o_valid[n] <= 1'b0;
                  o_err[n]   <= 1'b0;
               end else if (hit) begin
                  o_digits[4*n +: 4] <= nibble;
                  o_dp[n]            <= s_seg[7];
                  o_valid[n]         <= 1'b1;
                  o_err[n]           <= 1'b0;
               end else begin
                  o_err[n] <= 1'b1;
               end
            end
         end
      end
   end

   assign cap_mask = cap ? s_sel : '0;
   assign mask_or  = mask | cap_mask;

   // frame mask: pulse and clear once every digit has been captured
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mask    <= '0;
         o_frame <= 1'b0;
      end else if (&mask_or) begin
         mask    <= '0;
         o_frame <= 1'b1;
      end else begin
         mask    <= mask_or;
         o_frame <= 1'b0;
      end
   end

   // multi-hot strobe detector, one pulse per entry
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         multi_q   <= 1'b0;
         o_sel_err <= 1'b0;
      end else begin
         multi_q   <= multi;
         o_sel_err <= multi & ~multi_q;
      end
   end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder with a run-length reference model.
// Honours SEG7_CAP_BLANK_EN the same way as the design build.
module tb_seg7_capture_decoder;

   localparam int ND = 4;
   localparam int SC = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      seg;
   logic [ND-1:0]   sel;
   logic [4*ND-1:0] o_digits;
   logic [ND-1:0]   o_dp, o_valid, o_err;
   logic            o_sel_err, o_frame;

   always #5 clk = ~clk;

   seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_seg       (seg),
      .i_digit_sel (sel),
      .o_digits    (o_digits),
      .o_dp        (o_dp),
      .o_valid     (o_valid),
      .o_err       (o_err),
      .o_sel_err   (o_sel_err),
      .o_frame     (o_frame)
   );

   typedef struct packed {
      logic [4*ND-1:0] digits;
      logic [ND-1:0]   dp;
      logic [ND-1:0]   valid;
      logic [ND-1:0]   err;
      logic            sel_err;
      logic            frame;
   } obs_t;

   obs_t exp_q[$];
   obs_t m, e_obs, a_obs;
   int   errors = 0;
   int   checks = 0;

   logic [6:0] code_tab [16] = '{
      7'h5f, 7'h06, 7'h3b, 7'h2f, 7'h66, 7'h6d, 7'h7d, 7'h07,
      7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h59, 7'h3e, 7'h79, 7'h71
   };

   // reference model state: last sample, run length, multi-hot history
   logic [ND+7:0] in_d, prev;
   int            run;
   logic          multi_prev;
   logic [ND-1:0] fmask;

   function automatic int lookup(input logic [6:0] c);
      for (int i = 0; i < 16; i++)
         if (code_tab[i] == c) return i;
      return -1;
   endfunction

   task automatic tick(input logic r, input logic [ND-1:0] s,
                       input logic [7:0] g);
      logic [ND-1:0] xs;
      logic [7:0]    xg;
      int            idx, k, ones;
      @(negedge clk);
      rst = r;
      sel = s;
      seg = g;
      m.sel_err = 1'b0;
      m.frame   = 1'b0;
      if (r) begin
         m = '0;
         prev = '0;
         in_d = '0;
         run = 0;
         multi_prev = 1'b0;
         fmask = '0;
      end else begin
         {xs, xg} = in_d;
         ones = $countones(xs);
         if (ones == 1) begin
            run = ({xs, xg} == prev && run > 0) ? run + 1 : 1;
            if (run == SC) begin
               k = 0;
               for (int i = 0; i < ND; i++) if (xs[i]) k = i;
               idx = lookup(xg[6:0]);
`ifdef SEG7_CAP_BLANK_EN
               if (xg[6:0] == 7'h00) begin
                  m.valid[k] = 1'b0;
                  m.err[k]   = 1'b0;
               end else
`endif
               if (idx >= 0) begin
                  m.digits[4*k +: 4] = idx[3:0];
                  m.dp[k]    = xg[7];
                  m.valid[k] = 1'b1;
                  m.err[k]   = 1'b0;
               end else begin
                  m.err[k] = 1'b1;
               end
               fmask[k] = 1'b1;
               if (&fmask) begin
                  m.frame = 1'b1;
                  fmask = '0;
               end
            end
         end else begin
            run = 0;
         end
         m.sel_err = (ones > 1) && !multi_prev;
         multi_prev = (ones > 1);
         prev = {xs, xg};
         in_d = {s, g};
      end
      exp_q.push_back(m);
   endtask

   task automatic dwell(input int n, input logic [ND-1:0] s,
                        input logic [7:0] g);
      for (int i = 0; i < n; i++) tick(1'b0, s, g);
   endtask

   // monitor: compare every registered output snapshot against the model
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e_obs = exp_q.pop_front();
         a_obs = {o_digits, o_dp, o_valid, o_err, o_sel_err, o_frame};
         checks++;
         if (a_obs !== e_obs) begin
            errors++;
            $display("FAIL outputs t=%0t got dig=%h dp=%b val=%b err=%b selerr=%b frame=%b want dig=%h dp=%b val=%b err=%b selerr=%b frame=%b",
                     $time, a_obs.digits, a_obs.dp, a_obs.valid, a_obs.err,
                     a_obs.sel_err, a_obs.frame, e_obs.digits, e_obs.dp,
                     e_obs.valid, e_obs.err, e_obs.sel_err, e_obs.frame);
         end
      end
   end

   initial begin
      logic [ND-1:0] s;
      logic [7:0]    g;
      int            len, kind, b1, b2;
      rst = 1'b1;
      sel = '0;
      seg = '0;
      m = '0;
      in_d = '0;
      prev = '0;
      run = 0;
      multi_prev = 1'b0;
      fmask = '0;

      for (int i = 0; i < 3; i++) tick(1'b1, '0, 8'h00);

      dwell(16, 4'b0001, 8'h06);
      dwell(3, 4'b0000, 8'h00);

      dwell(15, 4'b0010, 8'hf7);
      dwell(1, 4'b0010, 8'hf6);
      dwell(16, 4'b0010, 8'hf7);
      dwell(2, 4'b0000, 8'h00);

      for (int sw = 0; sw < 2; sw++) begin
         dwell(20, 4'b0001, 8'h5f);
         dwell(20, 4'b0010, 8'h7f);
         dwell(20, 4'b0100, 8'h71);
         dwell(20, 4'b1000, 8'h3e);
      end

      dwell(16, 4'b0100, 8'h55);
      dwell(16, 4'b0100, 8'h6d);
      dwell(2, 4'b0000, 8'h00);

      dwell(10, 4'b0011, 8'h06);
      dwell(10, 4'b0001, 8'h06);
      tick(1'b1, 4'b0001, 8'h06);
      dwell(20, 4'b0000, 8'h00);

      dwell(16, 4'b1000, 8'h00);
      dwell(16, 4'b1000, 8'h80);
      dwell(2, 4'b0000, 8'h00);

      for (int d = 0; d < 80; d++) begin
         len  = $urandom_range(1, 24);
         kind = $urandom_range(0, 9);
         s = '0;
         if (kind == 1) begin
            b1 = $urandom_range(0, ND-1);
            b2 = (b1 + $urandom_range(1, ND-1)) % ND;
            s[b1] = 1'b1;
            s[b2] = 1'b1;
         end else if (kind > 1) begin
            s[$urandom_range(0, ND-1)] = 1'b1;
         end
         if ($urandom_range(0, 9) < 7)
            g = {1'($urandom_range(0, 1)), code_tab[$urandom_range(0, 15)]};
         else
            g = 8'($urandom);
         if ($urandom_range(0, 19) == 0) tick(1'b1, s, g);
         dwell(len, s, g);
      end

      dwell(300, 4'b0100, 8'h7d);
      dwell(4, 4'b0000, 8'h00);

      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
